// File: rtl/mem_datos_ws_if.sv
// Request/response bundle for the wait-state data memory: the initiator drives the request
// side, the memory answers with rdata, ready, err and busy.
interface mem_datos_ws_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sgn;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output req, we, size, sgn, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, size, sgn, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_datos_ws.sv
// Byte/half/word data memory with WAIT_CYC wait states; ready/err pulse WAIT_CYC+1 cycles after
// accept. One access in flight at a time: req is only sampled in IDLE, there is no other backpressure.
module mem_datos_ws #(
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2,
  parameter int ADDR_W   = 32
) (
  input  logic           clk,
  input  logic           reset,
  mem_datos_ws_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              we_q, sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              accept, misalign, oor, acc_err, wr_en;
  logic [3:0]        wr_be;
  logic [31:0]       wr_word, rd_word, ld_val;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  assign idx    = addr_q[IDX_W+1:2];
  assign accept = (state_q == IDLE) && bus.req;
  // Any address bit above the word index means the access falls outside the array.
  assign oor    = |(addr_q >> (IDX_W + 2));

  always_comb begin
    misalign = 1'b0;
    wr_be    = 4'b0000;
    wr_word  = wdata_q;
    case (size_q)
      2'b00: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        misalign = addr_q[0];
        wr_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        misalign = |addr_q[1:0];
        wr_be    = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
    acc_err = misalign | oor;
  end

  always_comb begin
    rd_word = mem[idx];
    case (addr_q[1:0])
      2'b00:   lane_b = rd_word[7:0];
      2'b01:   lane_b = rd_word[15:8];
      2'b10:   lane_b = rd_word[23:16];
      default: lane_b = rd_word[31:24];
    endcase
    lane_h = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   ld_val = {{24{sgn_q & lane_b[7]}}, lane_b};
      2'b01:   ld_val = {{16{sgn_q & lane_h[15]}}, lane_h};
      default: ld_val = rd_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYC);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          err_d   = acc_err;
          if (!acc_err) begin
            if (we_q) wr_en = ~reset;
            else      rdata_d = ld_val;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= bus.we;
        sgn_q   <= bus.sgn;
        size_q  <= bus.size;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
    end
  end

  // The array is deliberately outside the reset domain so its contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state_q == DONE);
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_mem_datos_ws.sv
// Directed bench: a WAIT_CYC=2 memory for functional/error/reset cases and a WAIT_CYC=0 one for
// latency and back-to-back acceptance with req held high.
module tb_mem_datos_ws;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_datos_ws_if #(.ADDR_W(32)) bus  ();
  mem_datos_ws_if #(.ADDR_W(32)) bus0 ();

  mem_datos_ws #(.DEPTH(256), .WAIT_CYC(2), .ADDR_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_datos_ws #(.DEPTH(256), .WAIT_CYC(0), .ADDR_W(32)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic s,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.size  = sz;
    bus.sgn   = s;
    bus.addr  = a;
    bus.wdata = wd;
  endtask

  // Accept edge, then count edges until ready; finishes one edge later back in IDLE.
  task automatic finish_acc(output int lat, output logic e, output logic bsy);
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bsy     = bus.busy;
    lat     = 0;
    while (!bus.ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = bus.err;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic s,
                        input logic [31:0] a, input logic [31:0] wd, input logic exp_err);
    int   lat;
    logic e, bsy;
    @(negedge clk);
    issue(w, sz, s, a, wd);
    finish_acc(lat, e, bsy);
    check({tag, ".lat"},  lat,          32'd3);
    check({tag, ".err"},  {31'b0, e},   {31'b0, exp_err});
    check({tag, ".busy"}, {31'b0, bsy}, 32'd1);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic s,
                      input logic [31:0] a, input logic [31:0] exp_rd);
    access(tag, 1'b0, sz, s, a, 32'h0, 1'b0);
    check({tag, ".rdata"}, bus.rdata, exp_rd);
  endtask

  initial begin
    int          lat;
    logic        e, bsy;
    logic [11:0] rdy_pat, bsy_pat, rdy_exp, bsy_exp;

    bus.req  = 1'b0;  bus.we  = 1'b0;  bus.size  = 2'b00;  bus.sgn  = 1'b0;
    bus.addr = '0;    bus.wdata = '0;
    bus0.req = 1'b0;  bus0.we = 1'b0;  bus0.size = 2'b00;  bus0.sgn = 1'b0;
    bus0.addr = '0;   bus0.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.outs", {29'b0, bus.ready, bus.err, bus.busy}, 32'd0);
    check("rst.rdata", bus.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    access("st_beef", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    load("ld_beef", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

    access("st_w4", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 1'b0);
    load("ldb13_s", 2'b00, 1'b1, 32'h13, 32'hFFFFFF80);
    load("ldb13_u", 2'b00, 1'b0, 32'h13, 32'h00000080);
    load("ldb11_s", 2'b00, 1'b1, 32'h11, 32'h0000007F);
    load("ldh10_s", 2'b01, 1'b1, 32'h10, 32'h00007F01);
    load("ldh12_s", 2'b01, 1'b1, 32'h12, 32'hFFFF80FF);
    load("ldh12_u", 2'b01, 1'b0, 32'h12, 32'h000080FF);

    access("stb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, 1'b0);
    check("stb11.rdata_kept", bus.rdata, 32'h000080FF);
    load("ldw_aa", 2'b10, 1'b0, 32'h10, 32'h80FFAA01);
    access("sth12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFEBEEF, 1'b0);
    load("ldw_beef", 2'b10, 1'b1, 32'h10, 32'hBEEFAA01);

    access("st_m0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h11111111, 1'b0);
    access("st_m1", 1'b1, 2'b10, 1'b0, 32'h4, 32'h22222222, 1'b0);
    load("ld_m1", 2'b10, 1'b0, 32'h4, 32'h22222222);
    access("e_stw02", 1'b1, 2'b10, 1'b0, 32'h2, 32'h99999999, 1'b1);
    check("e_stw02.rdata", bus.rdata, 32'h22222222);
    access("e_ldh01", 1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 1'b1);
    check("e_ldh01.rdata", bus.rdata, 32'h22222222);
    access("e_ldw_oor", 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 1'b1);
    check("e_ldw_oor.rdata", bus.rdata, 32'h22222222);
    access("e_sz11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    check("e_sz11.rdata", bus.rdata, 32'h22222222);
    load("ld_m0_after", 2'b10, 1'b0, 32'h0, 32'h11111111);
    load("ld_m1_after", 2'b10, 1'b0, 32'h4, 32'h22222222);

    // Reset lands while a store is still waiting; the store must never reach the array.
    access("st_m8", 1'b1, 2'b10, 1'b0, 32'h20, 32'h5A5A5A5A, 1'b0);
    @(negedge clk);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    check("mid.busy_before", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid.rst_outs", {29'b0, bus.ready, bus.err, bus.busy}, 32'd0);
    check("mid.rst_rdata", bus.rdata, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("mid.rst_hold_outs", {29'b0, bus.ready, bus.err, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    finish_acc(lat, e, bsy);
    check("post.busy_first_edge", {31'b0, bsy}, 32'd1);
    check("post.lat", lat, 32'd3);
    check("post.err", {31'b0, e}, 32'd0);
    check("post.rdata", bus.rdata, 32'h5A5A5A5A);

    // Zero-wait-state build.
    @(negedge clk);
    bus0.req = 1'b1;  bus0.we = 1'b1;  bus0.size = 2'b10;  bus0.addr = 32'h8;
    bus0.wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus0.req = 1'b0;
    lat = 0;
    while (!bus0.ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("wc0.st_lat", lat, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    bus0.req = 1'b1;  bus0.we = 1'b0;
    @(posedge clk);
    #1;
    bus0.req = 1'b0;
    lat = 0;
    while (!bus0.ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("wc0.ld_lat", lat, 32'd1);
    check("wc0.ld_rdata", bus0.rdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;

    @(negedge clk);
    bus0.req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      rdy_pat[k] = bus0.ready;
      bsy_pat[k] = bus0.busy;
      rdy_exp[k] = (k % 3 == 1);
      bsy_exp[k] = (k % 3 != 2);
    end
    bus0.req = 1'b0;
    check("wc0.ready_pattern", {20'b0, rdy_pat}, {20'b0, rdy_exp});
    check("wc0.busy_pattern",  {20'b0, bsy_pat}, {20'b0, bsy_exp});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_datos_ws.md
MEM_DATOS_WS -- requirements
Module: mem_datos_ws

Interface
REQ-001 Parameter DEPTH, default 256, meaning number of 32-bit words in the array (power of two, >=4).
REQ-002 Parameter WAIT_CYC, default 2, meaning number of wait states inserted per access (0..15).
REQ-003 Parameter ADDR_W, default 32, meaning byte-address width.
REQ-004 Port clk  input  1  rising-edge clock, single clock domain.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port req  input  1  access request, sampled only in IDLE.
REQ-007 Port we  input  1  1 = store, 0 = load.
REQ-008 Port size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 Port sgn  input  1  load sign-extension enable (1 = signed).
REQ-010 Port addr  input  ADDR_W  byte address.
REQ-011 Port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port rdata  output  32  registered load result, zero- or sign-extended.
REQ-013 Port ready  output  1  one-cycle completion pulse.
REQ-014 Port err  output  1  one-cycle error pulse, coincident with ready.
REQ-015 Port busy  output  1  high from the cycle after acceptance until ready is deasserted.

Function
REQ-016 Storage is an array named mem of DEPTH x 32 bits, word index addr[log2(DEPTH)+1:2], little-endian byte lanes, loadable by $readmemb from a bench.
REQ-017 FSM states are IDLE, WAIT, DONE.
REQ-018 IDLE with req=1 at a rising edge: capture we, size, sgn, addr and wdata; go to WAIT with wait counter = WAIT_CYC.
REQ-019 WAIT: decrement the counter each cycle. At counter = 0, perform the access and go to DONE.
REQ-020 If WAIT_CYC = 0, the access completes in the first WAIT cycle.
REQ-021 Latency: ready is high exactly WAIT_CYC+1 cycles after the accepting edge, for exactly one cycle (DONE). The FSM then returns to IDLE.
REQ-022 A new req is accepted in IDLE only. The earliest back-to-back accept is the edge ending DONE+1. req is ignored in WAIT and DONE.
REQ-023 Store byte: write wdata[7:0] to lane addr[1:0]. Store half: write wdata[15:0] to lanes addr[1]*2..+1. Store word: write all lanes. Other lanes are unchanged.
REQ-024 Load: select the lane(s) as for stores and right-align them. If sgn=1, extend with the MSB of the selected field; otherwise zero-fill. sgn is ignored for word loads.
REQ-025 Error conditions, all evaluated on the captured request:
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - size=11
  - word index >= DEPTH (upper address bits nonzero)
REQ-026 On error: mem is not written, rdata holds its previous value, and err=1 together with ready. Timing is identical to a normal access.
REQ-027 rdata changes only on a successful load completion. Stores leave rdata unchanged.
REQ-028 A load and a store to the same word never overlap, since only one access is in flight at a time. A read issued after a store returns the stored data.

Reset
REQ-029 Asserting reset at any time immediately forces:
  - state to IDLE
  - wait counter to 0
  - ready=0, err=0, busy=0, rdata=32'h0000_0000
REQ-030 reset does not clear mem contents.
REQ-031 An access in progress when reset asserts is abandoned: no write occurs if reset arrives before the completing edge.
REQ-032 The first req is accepted at the first rising edge with reset low.

Verification
REQ-033 WAIT_CYC=2, store word 32'hDEADBEEF at addr 0x10, then load word at 0x10. Required: ready pulses 3 cycles after each accept; rdata=32'hDEADBEEF; err=0.
REQ-034 mem[4]=32'h80FF7F01. Required:
  - load byte at 0x13, sgn=1 -> rdata=32'hFFFFFF80
  - load byte at 0x13, sgn=0 -> rdata=32'h00000080
  - load half at 0x10, sgn=1 -> rdata=32'h00007F01
  - load half at 0x12, sgn=1 -> rdata=32'hFFFF80FF
REQ-035 mem[4]=32'h80FF7F01, then store byte 8'hAA at 0x11 and load word at 0x10. Required: rdata=32'h80FFAA01.
REQ-036 Misaligned and out-of-range accesses. Required for each: ready=err=1 on the same cycle, mem[0..1] unchanged, rdata unchanged.
  - word store at 0x02
  - half load at 0x01
  - word load at byte address DEPTH*4
REQ-037 WAIT_CYC=0 build: a load completes with ready one cycle after accept. With req held high continuously, accepts occur every 3rd edge.
REQ-038 Reset mid-store: assert reset during WAIT of a store of 32'h12345678 to 0x20, then load 0x20 after release. Required: the original mem[8] value is returned, and all outputs were 0 during reset.
